// File: rtl/rv_wb_pkg.sv
// Shared definitions for the write-back stage: load funct3 codes, FSM encoding,
// latched load context and the load legality rule.
package rv_wb_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [0:0] {
        ST_IDLE      = 1'b0,
        ST_WAIT_LOAD = 1'b1
    } wb_state_e;

    typedef struct packed {
        logic [4:0] rd;
        logic       wen;
        logic [2:0] funct3;
        logic [1:0] addr_lo;
    } load_ctx_t;

    // Unknown funct3 encodings are reported the same way as misaligned accesses.
    function automatic logic load_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic bad;
        case (funct3)
            F3_LB, F3_LBU: bad = 1'b0;
            F3_LH, F3_LHU: bad = addr_lo[0];
            F3_LW:         bad = (addr_lo != 2'b00);
            default:       bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/wb_writer_if.sv
// Bus bundle between ex, the data-bus response and the register-file write port.
// slave is the write-back stage's view, master the surrounding pipeline's view.
interface wb_writer_if;
    import rv_wb_pkg::*;

    logic            ex_valid_i;
    logic            ex_ready_o;
    logic            ex_wen_i;
    logic [4:0]      ex_rd_i;
    logic [XLEN-1:0] ex_wdata_i;
    logic            ex_is_load_i;
    logic [2:0]      ex_funct3_i;
    logic [1:0]      ex_addr_lo_i;
    logic            mem_rvalid_i;
    logic [XLEN-1:0] mem_rdata_i;
    logic [4:0]      reg_waddr_o;
    logic [XLEN-1:0] reg_wdata_o;
    logic            reg_wen_o;
    logic            stall_o;
    logic            err_o;

    modport slave (
        input  ex_valid_i, ex_wen_i, ex_rd_i, ex_wdata_i, ex_is_load_i,
        input  ex_funct3_i, ex_addr_lo_i, mem_rvalid_i, mem_rdata_i,
        output ex_ready_o, reg_waddr_o, reg_wdata_o, reg_wen_o, stall_o, err_o
    );

    modport master (
        output ex_valid_i, ex_wen_i, ex_rd_i, ex_wdata_i, ex_is_load_i,
        output ex_funct3_i, ex_addr_lo_i, mem_rvalid_i, mem_rdata_i,
        input  ex_ready_o, reg_waddr_o, reg_wdata_o, reg_wen_o, stall_o, err_o
    );

endinterface

// File: rtl/wb_writer_load_align.sv
// Combinational load formatter: picks the addressed byte/half of the response word,
// sign- or zero-extends it, and flags misaligned or unknown load types.
module load_align
    import rv_wb_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] data,
    output logic            misalign
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane selection from the low address bits.
    always_comb begin
        byte_s = rdata[7:0];
        case (addr_lo)
            2'd0:    byte_s = rdata[7:0];
            2'd1:    byte_s = rdata[15:8];
            2'd2:    byte_s = rdata[23:16];
            2'd3:    byte_s = rdata[31:24];
            default: byte_s = rdata[7:0];
        endcase
        if (addr_lo[1]) begin
            half_s = rdata[31:16];
        end else begin
            half_s = rdata[15:0];
        end
    end

    // Extension by load type.
    always_comb begin
        data     = {XLEN{1'b0}};
        misalign = load_misaligned(funct3, addr_lo);
        case (funct3)
            F3_LB:   data = {{24{byte_s[7]}}, byte_s};
            F3_LH:   data = {{16{half_s[15]}}, half_s};
            F3_LW:   data = rdata;
            F3_LBU:  data = {24'd0, byte_s};
            F3_LHU:  data = {16'd0, half_s};
            default: data = {XLEN{1'b0}};
        endcase
    end

endmodule

// File: rtl/wb_writer.sv
// Write-back stage: sole driver of the register-file write port; one registered write per
// retired instruction. Optional load timeout is enabled by defining WB_TIMEOUT_EN.
module wb_writer
    import rv_wb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
)
(
    input  logic        clk,
    input  logic        rst,
    wb_writer_if.slave  bus
);

    localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);

    wb_state_e       state_r, state_s;
    load_ctx_t       ctx_r, ctx_s;
    logic [4:0]      reg_waddr_r, reg_waddr_s;
    logic [XLEN-1:0] reg_wdata_r, reg_wdata_s;
    logic            reg_wen_r, reg_wen_s;
    logic            err_r, err_s;

    logic [2:0]      align_f3_s;
    logic [1:0]      align_lo_s;
    logic [XLEN-1:0] align_data_s;
    logic            align_bad_s;

`ifdef WB_TIMEOUT_EN
    logic [7:0]      cnt_r, cnt_s;
`else
    logic            unused_timeout_s;
    assign unused_timeout_s = ^TIMEOUT_LIM;
`endif

    // The aligner checks the incoming load while idle and formats the response while waiting.
    always_comb begin
        if (state_r == ST_WAIT_LOAD) begin
            align_f3_s = ctx_r.funct3;
            align_lo_s = ctx_r.addr_lo;
        end else begin
            align_f3_s = bus.ex_funct3_i;
            align_lo_s = bus.ex_addr_lo_i;
        end
    end

    load_align u_load_align (
        .funct3   (align_f3_s),
        .addr_lo  (align_lo_s),
        .rdata    (bus.mem_rdata_i),
        .data     (align_data_s),
        .misalign (align_bad_s)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_s     = state_r;
        ctx_s       = ctx_r;
        reg_waddr_s = reg_waddr_r;
        reg_wdata_s = reg_wdata_r;
        reg_wen_s   = 1'b0;
        err_s       = 1'b0;
`ifdef WB_TIMEOUT_EN
        cnt_s       = cnt_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (bus.ex_valid_i && bus.ex_is_load_i) begin
                    if (align_bad_s) begin
                        err_s = 1'b1;
                    end else begin
                        state_s       = ST_WAIT_LOAD;
                        ctx_s.rd      = bus.ex_rd_i;
                        ctx_s.wen     = bus.ex_wen_i;
                        ctx_s.funct3  = bus.ex_funct3_i;
                        ctx_s.addr_lo = bus.ex_addr_lo_i;
`ifdef WB_TIMEOUT_EN
                        cnt_s         = 8'd0;
`endif
                    end
                end else if (bus.ex_valid_i) begin
                    // rd=0 retires without touching the write port; address/data keep their old values.
                    if (bus.ex_wen_i && (bus.ex_rd_i != 5'd0)) begin
                        reg_wen_s   = 1'b1;
                        reg_waddr_s = bus.ex_rd_i;
                        reg_wdata_s = bus.ex_wdata_i;
                    end else begin
                        reg_wen_s   = 1'b0;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT_LOAD: begin
                if (bus.mem_rvalid_i) begin
                    state_s = ST_IDLE;
                    if (ctx_r.wen && (ctx_r.rd != 5'd0)) begin
                        reg_wen_s   = 1'b1;
                        reg_waddr_s = ctx_r.rd;
                        reg_wdata_s = align_data_s;
                    end else begin
                        reg_wen_s   = 1'b0;
                    end
`ifdef WB_TIMEOUT_EN
                end else if (cnt_r == TIMEOUT_LIM) begin
                    state_s = ST_IDLE;
                    err_s   = 1'b1;
                end else begin
                    cnt_s   = cnt_r + 8'd1;
                end
`else
                end else begin
                    state_s = ST_WAIT_LOAD;
                end
`endif
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, load context and registered write-port outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            ctx_r       <= '0;
            reg_waddr_r <= 5'd0;
            reg_wdata_r <= {XLEN{1'b0}};
            reg_wen_r   <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            state_r     <= state_s;
            ctx_r       <= ctx_s;
            reg_waddr_r <= reg_waddr_s;
            reg_wdata_r <= reg_wdata_s;
            reg_wen_r   <= reg_wen_s;
            err_r       <= err_s;
        end
    end

`ifdef WB_TIMEOUT_EN
    // Wait-cycle counter for the load timeout.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= 8'd0;
        end else begin
            cnt_r <= cnt_s;
        end
    end
`endif

    assign bus.ex_ready_o  = (state_r == ST_IDLE);
    assign bus.stall_o     = (state_r == ST_WAIT_LOAD);
    assign bus.reg_waddr_o = reg_waddr_r;
    assign bus.reg_wdata_o = reg_wdata_r;
    assign bus.reg_wen_o   = reg_wen_r;
    assign bus.err_o       = err_r;

endmodule

// File: tb/tb_wb_writer.sv
// Randomized self-checking bench for wb_writer against a behavioural write-back model.
module tb_wb_writer;
    import rv_wb_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wb_writer_if bus ();

    wb_writer #(.TIMEOUT_CYCLES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          vec_cnt = 0;
    int          err_cnt = 0;
    logic [4:0]  last_waddr = 5'd0;
    logic [31:0] last_wdata = 32'd0;
    logic [40:0] exp_v;
    logic [40:0] obs_v;

    // {wen, waddr, wdata, err, stall, ready}
    function automatic logic [40:0] observed();
        return {bus.reg_wen_o, bus.reg_waddr_o, bus.reg_wdata_o, bus.err_o, bus.stall_o, bus.ex_ready_o};
    endfunction

    function automatic logic ref_legal(input logic [2:0] f3, input logic [1:0] lo);
        int unsigned a;
        a = lo;
        if (f3 == 3'd0 || f3 == 3'd4) return 1'b1;
        if (f3 == 3'd1 || f3 == 3'd5) return (a % 2 == 0);
        if (f3 == 3'd2) return (a == 0);
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] w);
        int unsigned b;
        int unsigned h;
        int unsigned sh;
        sh = lo;
        b  = (w >> (8 * sh)) & 32'h0000_00FF;
        h  = (w >> (16 * (sh / 2))) & 32'h0000_FFFF;
        case (f3)
            3'd0:    return (b >= 128) ? (b + 32'hFFFF_FF00) : b;
            3'd1:    return (h >= 32768) ? (h + 32'hFFFF_0000) : h;
            3'd2:    return w;
            3'd4:    return b;
            3'd5:    return h;
            default: return 32'd0;
        endcase
    endfunction

    task automatic idle_inputs();
        bus.ex_valid_i   = 1'b0;
        bus.ex_wen_i     = 1'b0;
        bus.ex_rd_i      = 5'd0;
        bus.ex_wdata_i   = 32'd0;
        bus.ex_is_load_i = 1'b0;
        bus.ex_funct3_i  = 3'd0;
        bus.ex_addr_lo_i = 2'd0;
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rdata_i  = 32'd0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        exp_v = {1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1};
        obs_v = observed();
        vec_cnt++;
        if (obs_v !== exp_v) begin
            err_cnt++;
            $display("FAIL reset_hold: got %h expected %h", obs_v, exp_v);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        obs_v = observed();
        vec_cnt++;
        if (obs_v !== exp_v) begin
            err_cnt++;
            $display("FAIL reset_release: got %h expected %h", obs_v, exp_v);
        end
    endtask

    // Isolated ALU ops, each followed by an idle cycle.
    task automatic test_alu();
        logic [4:0]  rd;
        logic        wen;
        logic [31:0] d;
        for (int i = 0; i < 18; i++) begin
            if (i == 0) begin
                rd = 5'd5; wen = 1'b1; d = 32'h1234_5678;
            end else if (i == 1) begin
                rd = 5'd0; wen = 1'b1; d = 32'hDEAD_BEEF;
            end else begin
                rd  = (i % 5 == 0) ? 5'd0 : 5'($urandom_range(0, 31));
                wen = 1'($urandom_range(0, 3) != 0);
                d   = $urandom;
            end
            @(negedge clk);
            bus.ex_valid_i   = 1'b1;
            bus.ex_is_load_i = 1'b0;
            bus.ex_wen_i     = wen;
            bus.ex_rd_i      = rd;
            bus.ex_wdata_i   = d;
            bus.ex_funct3_i  = 3'($urandom);
            bus.ex_addr_lo_i = 2'($urandom);
            @(posedge clk);
            #1;
            if (wen && rd != 5'd0) begin
                last_waddr = rd;
                last_wdata = d;
            end
            exp_v = {wen && rd != 5'd0, last_waddr, last_wdata, 1'b0, 1'b0, 1'b1};
            obs_v = observed();
            vec_cnt++;
            if (obs_v !== exp_v) begin
                err_cnt++;
                $display("FAIL alu_write[%0d]: got %h expected %h", i, obs_v, exp_v);
            end
            @(negedge clk);
            bus.ex_valid_i = 1'b0;
            @(posedge clk);
            #1;
            exp_v = {1'b0, last_waddr, last_wdata, 1'b0, 1'b0, 1'b1};
            obs_v = observed();
            vec_cnt++;
            if (obs_v !== exp_v) begin
                err_cnt++;
                $display("FAIL alu_idle[%0d]: got %h expected %h", i, obs_v, exp_v);
            end
        end
    endtask

    // ex_valid held high: one write retires every cycle.
    task automatic test_back_to_back();
        logic [4:0]  rd;
        logic        wen;
        logic [31:0] d;
        for (int i = 0; i < 24; i++) begin
            rd  = 5'($urandom_range(0, 31));
            wen = 1'($urandom_range(0, 4) != 0);
            d   = $urandom;
            @(negedge clk);
            bus.ex_valid_i   = 1'b1;
            bus.ex_is_load_i = 1'b0;
            bus.ex_wen_i     = wen;
            bus.ex_rd_i      = rd;
            bus.ex_wdata_i   = d;
            @(posedge clk);
            #1;
            if (wen && rd != 5'd0) begin
                last_waddr = rd;
                last_wdata = d;
            end
            exp_v = {wen && rd != 5'd0, last_waddr, last_wdata, 1'b0, 1'b0, 1'b1};
            obs_v = observed();
            vec_cnt++;
            if (obs_v !== exp_v) begin
                err_cnt++;
                $display("FAIL b2b[%0d]: got %h expected %h", i, obs_v, exp_v);
            end
        end
        @(negedge clk);
        bus.ex_valid_i = 1'b0;
    endtask

    // One load through accept, wait, response (or error), and the cycle after.
    task automatic load_txn(input logic [2:0] f3, input logic [1:0] lo, input logic [4:0] rd,
                            input logic wen, input logic [31:0] w, input int gap);
        logic wr;
        @(negedge clk);
        bus.ex_valid_i   = 1'b1;
        bus.ex_is_load_i = 1'b1;
        bus.ex_funct3_i  = f3;
        bus.ex_addr_lo_i = lo;
        bus.ex_rd_i      = rd;
        bus.ex_wen_i     = wen;
        bus.ex_wdata_i   = $urandom;
        @(posedge clk);
        #1;
        if (!ref_legal(f3, lo)) begin
            exp_v = {1'b0, last_waddr, last_wdata, 1'b1, 1'b0, 1'b1};
            obs_v = observed();
            vec_cnt++;
            if (obs_v !== exp_v) begin
                err_cnt++;
                $display("FAIL load_err f3=%0d lo=%0d: got %h expected %h", f3, lo, obs_v, exp_v);
            end
            @(negedge clk);
            bus.ex_valid_i = 1'b0;
            @(posedge clk);
            #1;
            exp_v = {1'b0, last_waddr, last_wdata, 1'b0, 1'b0, 1'b1};
            obs_v = observed();
            vec_cnt++;
            if (obs_v !== exp_v) begin
                err_cnt++;
                $display("FAIL load_err_pulse f3=%0d: got %h expected %h", f3, obs_v, exp_v);
            end
            return;
        end
        exp_v = {1'b0, last_waddr, last_wdata, 1'b0, 1'b1, 1'b0};
        obs_v = observed();
        vec_cnt++;
        if (obs_v !== exp_v) begin
            err_cnt++;
            $display("FAIL load_accept f3=%0d: got %h expected %h", f3, obs_v, exp_v);
        end
        @(negedge clk);
        bus.ex_valid_i = 1'b0;
        for (int g = 0; g < gap; g++) begin
            @(posedge clk);
            #1;
            obs_v = observed();
            vec_cnt++;
            if (obs_v !== exp_v) begin
                err_cnt++;
                $display("FAIL load_wait[%0d]: got %h expected %h", g, obs_v, exp_v);
            end
        end
        @(negedge clk);
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = w;
        @(posedge clk);
        #1;
        wr = wen && (rd != 5'd0);
        if (wr) begin
            last_waddr = rd;
            last_wdata = ref_load(f3, lo, w);
        end
        exp_v = {wr, last_waddr, last_wdata, 1'b0, 1'b0, 1'b1};
        obs_v = observed();
        vec_cnt++;
        if (obs_v !== exp_v) begin
            err_cnt++;
            $display("FAIL load_data f3=%0d lo=%0d rdata=%h: got %h expected %h", f3, lo, w, obs_v, exp_v);
        end
        @(negedge clk);
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rdata_i  = $urandom;
        @(posedge clk);
        #1;
        exp_v = {1'b0, last_waddr, last_wdata, 1'b0, 1'b0, 1'b1};
        obs_v = observed();
        vec_cnt++;
        if (obs_v !== exp_v) begin
            err_cnt++;
            $display("FAIL load_pulse f3=%0d: got %h expected %h", f3, obs_v, exp_v);
        end
    endtask

    task automatic test_load();
        load_txn(3'b000, 2'd3, 5'd9,  1'b1, 32'h80FF_0000, 2);
        load_txn(3'b100, 2'd3, 5'd10, 1'b1, 32'h80FF_0000, 0);
        load_txn(3'b101, 2'd2, 5'd11, 1'b1, 32'h80FF_0000, 1);
        load_txn(3'b010, 2'd0, 5'd12, 1'b1, 32'h80FF_0000, 3);
        load_txn(3'b001, 2'd2, 5'd13, 1'b1, 32'h80FF_0000, 0);
        load_txn(3'b010, 2'd0, 5'd0,  1'b1, 32'hCAFE_F00D, 1);
        for (int i = 0; i < 30; i++) begin
            load_txn(3'($urandom), 2'($urandom), 5'($urandom), 1'($urandom_range(0, 5) != 0),
                     $urandom, int'($urandom_range(0, 4)));
        end
    endtask

    task automatic test_misalign();
        load_txn(3'b010, 2'd1, 5'd4, 1'b1, 32'h1111_2222, 0);
        load_txn(3'b001, 2'd3, 5'd4, 1'b1, 32'h1111_2222, 0);
        load_txn(3'b101, 2'd1, 5'd4, 1'b1, 32'h1111_2222, 0);
        load_txn(3'b011, 2'd0, 5'd4, 1'b1, 32'h1111_2222, 0);
        load_txn(3'b110, 2'd0, 5'd4, 1'b1, 32'h1111_2222, 0);
        load_txn(3'b111, 2'd0, 5'd4, 1'b1, 32'h1111_2222, 0);
    endtask

    task automatic test_stray_rvalid();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.mem_rvalid_i = 1'b1;
            bus.mem_rdata_i  = $urandom;
            @(posedge clk);
            #1;
            exp_v = {1'b0, last_waddr, last_wdata, 1'b0, 1'b0, 1'b1};
            obs_v = observed();
            vec_cnt++;
            if (obs_v !== exp_v) begin
                err_cnt++;
                $display("FAIL stray_rvalid[%0d]: got %h expected %h", i, obs_v, exp_v);
            end
            @(negedge clk);
            bus.mem_rvalid_i = 1'b0;
        end
    endtask

    task automatic test_reset_mid_wait();
        @(negedge clk);
        bus.ex_valid_i   = 1'b1;
        bus.ex_is_load_i = 1'b0;
        bus.ex_wen_i     = 1'b1;
        bus.ex_rd_i      = 5'd7;
        bus.ex_wdata_i   = 32'hA5A5_0F0F;
        @(negedge clk);
        bus.ex_is_load_i = 1'b1;
        bus.ex_funct3_i  = 3'b010;
        bus.ex_addr_lo_i = 2'd0;
        bus.ex_rd_i      = 5'd8;
        @(posedge clk);
        #1;
        exp_v = {1'b0, 5'd7, 32'hA5A5_0F0F, 1'b0, 1'b1, 1'b0};
        obs_v = observed();
        vec_cnt++;
        if (obs_v !== exp_v) begin
            err_cnt++;
            $display("FAIL rstmid_wait: got %h expected %h", obs_v, exp_v);
        end
        @(negedge clk);
        bus.ex_valid_i = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        last_waddr = 5'd0;
        last_wdata = 32'd0;
        exp_v = {1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1};
        obs_v = observed();
        vec_cnt++;
        if (obs_v !== exp_v) begin
            err_cnt++;
            $display("FAIL rstmid_async: got %h expected %h", obs_v, exp_v);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 32'h7777_7777;
        @(posedge clk);
        #1;
        obs_v = observed();
        vec_cnt++;
        if (obs_v !== exp_v) begin
            err_cnt++;
            $display("FAIL rstmid_rvalid: got %h expected %h", obs_v, exp_v);
        end
        @(negedge clk);
        bus.mem_rvalid_i = 1'b0;
    endtask

`ifdef WB_TIMEOUT_EN
    task automatic test_timeout();
        @(negedge clk);
        bus.ex_valid_i   = 1'b1;
        bus.ex_is_load_i = 1'b1;
        bus.ex_funct3_i  = 3'b000;
        bus.ex_addr_lo_i = 2'd1;
        bus.ex_rd_i      = 5'd3;
        bus.ex_wen_i     = 1'b1;
        @(negedge clk);
        bus.ex_valid_i = 1'b0;
        exp_v = {1'b0, last_waddr, last_wdata, 1'b0, 1'b1, 1'b0};
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            obs_v = observed();
            vec_cnt++;
            if (obs_v !== exp_v) begin
                err_cnt++;
                $display("FAIL timeout_wait[%0d]: got %h expected %h", c, obs_v, exp_v);
            end
        end
        @(posedge clk);
        #1;
        exp_v = {1'b0, last_waddr, last_wdata, 1'b1, 1'b0, 1'b1};
        obs_v = observed();
        vec_cnt++;
        if (obs_v !== exp_v) begin
            err_cnt++;
            $display("FAIL timeout_err: got %h expected %h", obs_v, exp_v);
        end
        @(negedge clk);
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 32'h1234_5678;
        @(posedge clk);
        #1;
        exp_v = {1'b0, last_waddr, last_wdata, 1'b0, 1'b0, 1'b1};
        obs_v = observed();
        vec_cnt++;
        if (obs_v !== exp_v) begin
            err_cnt++;
            $display("FAIL timeout_stray: got %h expected %h", obs_v, exp_v);
        end
        @(negedge clk);
        bus.mem_rvalid_i = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_alu();
        test_back_to_back();
        test_load();
        test_misalign();
        test_stray_rvalid();
        test_reset_mid_wait();
`ifdef WB_TIMEOUT_EN
        test_timeout();
`endif
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
